fan_timer_countdown: RTL
========================

Name: fan_timer_countdown

Overview:
Countdown side of the fan timer. The user loads a run time in STEP_SEC increments. An internal 1 s prescaler then counts it down while the fan-enable output is held high. When the count reaches zero the block drops fan enable, pulses o_done and returns to idle. It sits between the debounced button pulses and the fan driver / 7-segment display logic.

Parameters:
CLK_FREQ, 100_000_000, i_clk cycles per 1 s tick (sim uses 4)
STEP_SEC, 60, seconds added per i_add pulse
MAX_SEC, 540, saturation limit for remaining time
CNT_W, 10, width of remaining-seconds counter; must satisfy 2^CNT_W > MAX_SEC

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_add  in  1  single-cycle pulse: add STEP_SEC to remaining time
i_start  in  1  single-cycle pulse: start / pause / resume toggle
i_button_C  in  1  single-cycle pulse: cancel; synchronous clear
o_remain  out  CNT_W  remaining seconds, registered
o_state  out  2  0=IDLE, 1=RUN, 2=PAUSE (3 unused)
o_fan_en  out  1  high exactly while state==RUN
o_done  out  1  one-cycle pulse on natural expiry

Behaviour:
- Reset (async, i_reset=1): state=IDLE, o_remain=0, prescaler=0, o_fan_en=0, o_done=0. Reset mid-RUN aborts immediately; no o_done.
- All other logic is synchronous to posedge i_clk. Inputs are already debounced, one-cycle pulses.
- Priority per cycle: i_button_C > i_start > tick/i_add.
- Cancel (i_button_C=1), any state:
  - next state=IDLE, o_remain=0, prescaler=0, o_done=0.
  - Any i_add/i_start in the same cycle is ignored.
- Add (i_add=1), accepted in IDLE, RUN and PAUSE:
  - o_remain <= min(o_remain + STEP_SEC, MAX_SEC).
  - Sum computed at CNT_W+1 bits before compare, so no wrap.
- Prescaler: counts 0..CLK_FREQ-1 only in RUN.
  - Holds its value in PAUSE.
  - Cleared on IDLE->RUN and on cancel.
  - tick = (state==RUN && prescaler==CLK_FREQ-1); prescaler wraps to 0 on tick.
- FSM:
  - IDLE: i_start with registered o_remain!=0 -> RUN (prescaler cleared). i_start with o_remain==0 is ignored (stays IDLE). i_add and i_start in the same cycle from o_remain==0: add applies, start ignored.
  - RUN: i_start -> PAUSE. If a tick coincides, the tick is dropped and the prescaler holds at CLK_FREQ-1, so the first cycle after resume ticks.
  - RUN on tick, no add: o_remain <= o_remain-1. If o_remain was 1: o_remain <= 0, state <= IDLE, o_done=1 for exactly one cycle (the cycle after the tick edge).
  - RUN on tick with i_add: o_remain <= min(o_remain-1+STEP_SEC, MAX_SEC). No expiry even if o_remain was 1.
  - PAUSE: i_start -> RUN (prescaler not cleared). o_remain frozen except for i_add.
- Outputs:
  - o_fan_en decoded from the registered state: high the cycle RUN is entered, low the cycle it is left.
  - o_remain never underflows; in RUN it is always >= 1.
- o_remain updates on the same edge as the tick (latency 0 after tick detection).

Test Plan:
1. Reset, then 3x i_add, then i_start (CLK_FREQ=4) -> o_remain=180, state=RUN, o_fan_en=1; after 4 clocks o_remain=179; after 720 clocks o_remain=0, o_done pulses 1 cycle, state=IDLE, fan_en=0.
2. 10x i_add from IDLE -> o_remain saturates at 540; i_add during RUN at o_remain=539 -> 540.
3. RUN with prescaler=2, i_start -> PAUSE, o_remain frozen for 20 clocks; i_start -> RUN; first decrement occurs 1 clock later (prescaler resumes at 2->3).
4. RUN with o_remain=1, i_add coincident with tick -> o_remain=60, no o_done, state stays RUN.
5. i_button_C asserted together with i_start in RUN at o_remain=100 -> state=IDLE, o_remain=0, fan_en=0, no o_done; i_start in IDLE with o_remain=0 -> stays IDLE.
6. Async i_reset pulsed mid-clock during RUN -> outputs cleared immediately, without waiting for a clock edge; no o_done after release.

Source files
------------

// File: rtl/fan_timer_countdown.sv
// Fan timer countdown: loads run time in STEP_SEC steps, counts it down
// with a 1 s prescaler while driving fan enable, pulses done on expiry.
module fan_timer_countdown #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int STEP_SEC = 60,
    parameter int MAX_SEC  = 540,
    parameter int CNT_W    = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_add,
    input  logic             i_start,
    input  logic             i_button_C,
    output logic [CNT_W-1:0] o_remain,
    output logic [1:0]       o_state,
    output logic             o_fan_en,
    output logic             o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]  PMAX  = PW'(CLK_FREQ - 1);
    localparam logic [CNT_W:0] STEPV = (CNT_W + 1)'(STEP_SEC);
    localparam logic [CNT_W:0] MAXV  = (CNT_W + 1)'(MAX_SEC);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q, done_d;

    logic             tick;
    logic             tick_eff;
    logic [CNT_W:0]   add_sum;
    logic [CNT_W:0]   tick_sum;
    logic [CNT_W-1:0] add_sat;
    logic [CNT_W-1:0] tick_sat;

    assign tick     = (state_q == S_RUN) && (presc_q == PMAX);
    // A start in RUN (pause) swallows a coincident tick.
    assign tick_eff = tick && !i_start;

    // Sums are one bit wider than the counter so saturation never wraps.
    assign add_sum  = {1'b0, remain_q} + STEPV;
    assign tick_sum = {1'b0, remain_q} - 1'b1 + STEPV;
    assign add_sat  = (add_sum > MAXV) ? MAXV[CNT_W-1:0] : add_sum[CNT_W-1:0];
    assign tick_sat = (tick_sum > MAXV) ? MAXV[CNT_W-1:0] : tick_sum[CNT_W-1:0];

    // Next-state logic: cancel first, then start/pause/resume, then tick/add.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        if (i_button_C) begin
            state_d  = S_IDLE;
            remain_d = '0;
            presc_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start && (remain_q != '0)) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    if (i_start) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (i_start) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (tick_eff) begin
                if (i_add) begin
                    remain_d = tick_sat;
                end else if (remain_q == CNT_W'(1)) begin
                    remain_d = '0;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                end else begin
                    remain_d = remain_q - 1'b1;
                end
            end else if (i_add) begin
                remain_d = add_sat;
            end
        end
    end

    // State, counter, prescaler and done pulse registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    assign o_remain = remain_q;
    assign o_state  = state_q;
    assign o_fan_en = (state_q == S_RUN);
    assign o_done   = done_q;

endmodule
